// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - round-robin arbiter sharing one usart_tx among NUM_REQ byte requesters
// Optional watchdog: define UART_ARB_TIMEOUT_EN to add the WAIT_HI/WAIT_LO timeout and the err port.
module uart_tx_arb #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] data_in,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   done,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic                 busy,
  output logic [ID_W-1:0]      cur_id
`ifdef UART_ARB_TIMEOUT_EN
  ,
  output logic                 err
`endif
);

  localparam bit CFG_OK = (NUM_REQ >= 2) && (NUM_REQ <= 8) &&
                          ((1 << ID_W) >= NUM_REQ) && (TIMEOUT_CYC >= 1);

  // Reject parameter sets that cannot index the requesters.
  if (!CFG_OK) begin : g_cfg_check
    $error("uart_tx_arb: illegal NUM_REQ/ID_W/TIMEOUT_CYC combination");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_WAIT_HI = 3'd2,
    S_WAIT_LO = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t          state;
  logic [ID_W-1:0] last_grant;
  logic            lg_bad;
  logic            gnt_found;
  logic [ID_W-1:0] gnt_idx;
  logic [7:0]      gnt_byte;
  int              scan_k;
  logic            wd_hit;

  assign lg_bad = (int'(last_grant) >= NUM_REQ);

  // Round-robin scan starting just after the last completed requester.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_byte  = '0;
    scan_k    = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      scan_k = (int'(last_grant) + i) % NUM_REQ;
      if (!gnt_found && req[scan_k]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(scan_k);
        gnt_byte  = data_in[8*scan_k +: 8];
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wd_cnt;

  assign wd_hit = (wd_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Watchdog counts only while lingering in a wait state; any state change clears it, err is sticky.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt <= '0;
      err    <= 1'b0;
    end else if ((state == S_WAIT_HI && !tx_busy) || (state == S_WAIT_LO && tx_busy)) begin
      if (wd_hit) begin
        wd_cnt <= '0;
        err    <= 1'b1;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end else begin
      wd_cnt <= '0;
    end
  end
`else
  assign wd_hit = 1'b0;
`endif

  // Main sequencer: grant, start pulse, follow tx_busy high then low, report completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      last_grant <= ID_W'(NUM_REQ - 1);
      ack        <= '0;
      done       <= '0;
      tx_start   <= 1'b0;
      tx_data    <= '0;
      busy       <= 1'b0;
      cur_id     <= '0;
    end else begin
      ack  <= '0;
      done <= '0;
      case (state)
        S_IDLE: begin
          if (lg_bad) begin
            last_grant <= ID_W'(NUM_REQ - 1);
          end else if (gnt_found) begin
            tx_data <= gnt_byte;
            cur_id  <= gnt_idx;
            ack     <= NUM_REQ'(1) << gnt_idx;
            busy    <= 1'b1;
            state   <= S_START;
          end
        end
        S_START: begin
          tx_start <= 1'b1;
          state    <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (tx_busy) begin
            // Drop start as soon as the transmitter is running so it never sees a second start.
            tx_start <= 1'b0;
            state    <= S_WAIT_LO;
          end else if (wd_hit) begin
            tx_start <= 1'b0;
            done     <= NUM_REQ'(1) << cur_id;
            busy     <= 1'b0;
            state    <= S_DONE;
          end
        end
        S_WAIT_LO: begin
          if (!tx_busy || wd_hit) begin
            done  <= NUM_REQ'(1) << cur_id;
            busy  <= 1'b0;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          last_grant <= cur_id;
          state      <= S_IDLE;
        end
        default: begin
          tx_start <= 1'b0;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Round-robin arbiter and sequencer that shares one usart_tx transmitter among NUM_REQ byte requesters.
- Selects a requester, latches its byte and pulses the transmitter start input.
- Tracks the transmitter busy flag through start, data and stop bits, then signals per-requester completion.
- Sits between client logic (command/status/debug sources) and the single usart_tx instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of cur_id; must satisfy 2^ID_W >= NUM_REQ
TIMEOUT_CYC, 64, watchdog limit in clk cycles; used only with UART_ARB_TIMEOUT_EN

Ports:
clk  in  1  system clock; all logic on rising edge
reset_n  in  1  asynchronous active-low reset
req  in  NUM_REQ  per-requester request; held high with data stable until ack
data_in  in  NUM_REQ*8  byte for requester k on bits [8k+7:8k]
ack  out  NUM_REQ  one-cycle pulse: requester's byte latched, req may drop
done  out  NUM_REQ  one-cycle pulse: requester's byte fully transmitted (stop bit finished)
tx_start  out  1  to usart_tx start
tx_data  out  8  to usart_tx tx_dat; holds the latched byte for the whole transfer
tx_busy  in  1  from usart_tx is_trns
busy  out  1  high from grant until done pulse
cur_id  out  ID_W  index of the granted requester; valid while busy
err  out  1  timeout flag; present only with UART_ARB_TIMEOUT_EN

Behaviour:
- Reset (async, reset_n=0):
  - All outputs 0: ack, done, tx_start, tx_data, busy, cur_id, err.
  - State IDLE; last_grant = NUM_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, START, WAIT_HI, WAIT_LO, DONE.
- IDLE:
  - If any req is high, grant the first set bit scanning last_grant+1, last_grant+2, ... with modulo-NUM_REQ wrap.
  - In the same cycle: latch the data into tx_data, set cur_id, pulse that requester's ack, set busy=1, go to START.
  - If no req is high, stay in IDLE.
- START: tx_start=1; go to WAIT_HI.
- WAIT_HI:
  - Keep tx_start=1 until tx_busy=1 is sampled.
  - On tx_busy=1: drop tx_start and go to WAIT_LO. Dropping start here prevents usart_tx from seeing a second start.
- WAIT_LO: wait for tx_busy=0, then go to DONE.
- DONE:
  - Pulse done[cur_id] for one cycle, set busy=0, set last_grant=cur_id.
  - Go to IDLE; re-arbitration happens in the following cycle.
- Throughput:
  - Minimum gap between grants is 1 cycle of IDLE after DONE.
  - The latch-to-done interval is set by the tx_busy duration.
- Fairness:
  - A requester that just completed has lowest priority next round.
  - With all req high, grants go 0,1,2,3,0,...
- Simultaneous events:
  - req changes outside IDLE are ignored; only IDLE samples req.
  - The granted requester may re-assert req in the cycle after ack. It is queued like any other requester.
- Deasserting req before ack: legal; that requester is simply not granted.
- Data and ID stability: tx_data and cur_id are stable from grant to the DONE cycle inclusive.
- Async reset mid-transfer:
  - Outputs clear immediately; no done pulse is issued.
  - tx_start drops, so usart_tx finishes its current frame on its own.
  - The arbiter returns to IDLE and may re-arbitrate while tx_busy is still 1. The system must reset usart_tx together with this block.
- Out-of-range last_grant or an illegal state: recover to IDLE on the next clock.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- With the macro defined:
  - A cycle counter runs while in WAIT_HI or WAIT_LO; it clears on state entry.
  - When the counter reaches TIMEOUT_CYC: set err=1 (sticky until reset), drop tx_start, and go to DONE. The done pulse is still issued so the requester is not starved.
- Without the macro: no counter, no err port; WAIT_HI and WAIT_LO wait indefinitely.

Test Plan:
- Single request: req=4'b0001, data_in[7:0]=8'hA5 -> ack[0] pulse, tx_data=8'hA5, tx_start high until tx_busy=1 -> done[0] one cycle after tx_busy falls; busy high throughout.
- Round robin: all four req held high, distinct bytes 8'h10..8'h13 -> grants 0,1,2,3,0 in order; each done pulse precedes the next ack; exactly one tx_start rise per byte.
- Priority rotation: after granting 2, assert req=4'b0101 in DONE -> next grant is 0 (scan 3,0), not 2.
- Request withdrawn: req[1] pulsed for one cycle while busy serving 0 -> no ack[1], no grant to 1.
- Reset mid-frame: reset_n low during WAIT_LO -> all outputs 0 asynchronously; after release, req[3] -> grant 3 only after priority scan from 0 (last_grant reset to NUM_REQ-1).
- Timeout (UART_ARB_TIMEOUT_EN, TIMEOUT_CYC=64): hold tx_busy=0 after grant -> err=1 and done pulse 64 cycles after entering WAIT_HI; tx_start low thereafter.
